// File: rtl/img_ctrl_pkg.sv
// Shared types and constants for the recognition frame sequencer.
// The nibble helper flags any character position the recogniser could not resolve.
package img_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCATE  = 2'd1,
    PROJECT = 2'd2,
    RECOG   = 2'd3
  } ctrl_state_t;

  localparam logic [3:0] NIBBLE_INVALID     = 4'hF;
  localparam int         DEF_STABLE_CNT     = 3;
  localparam int         DEF_TIMEOUT_FRAMES = 4;

  // Only the low `nibbles` positions of a zero-extended value are inspected.
  function automatic logic has_invalid_nibble(input logic [63:0] value, input int nibbles);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ((i < nibbles) && (value[i*4 +: 4] == NIBBLE_INVALID)) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/recog_frame_ctrl_voter.sv
// Stability voter: publishes a recognition result once it repeats STABLE_CNT times.
// Any unresolved nibble breaks the run; a clear drops the run but keeps the last digit.
module digit_voter
  import img_ctrl_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int NUM_WIDTH  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [NUM_WIDTH-1:0] digit_in,
  output logic [NUM_WIDTH-1:0] digit,
  output logic                 digit_valid,
  output logic                 digit_upd
);

  localparam int            MW        = $clog2(STABLE_CNT + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_CNT);

  logic [NUM_WIDTH-1:0] last_r, last_nxt_s;
  logic [MW-1:0]        match_r, match_nxt_s;
  logic [NUM_WIDTH-1:0] digit_r;
  logic                 valid_r, upd_r;
  logic                 invalid_s, publish_s;

  assign invalid_s = has_invalid_nibble(64'(digit_in), NUM_WIDTH / 4);

  // Vote on a strobed sample and decide whether the stable value is new.
  always_comb begin
    last_nxt_s  = last_r;
    match_nxt_s = match_r;
    publish_s   = 1'b0;
    if (sample) begin
      if (invalid_s) begin
        match_nxt_s = '0;
      end else if (digit_in == last_r) begin
        if (match_r < MATCH_MAX) begin
          match_nxt_s = match_r + MW'(1);
        end else begin
          match_nxt_s = match_r;
        end
      end else begin
        last_nxt_s  = digit_in;
        match_nxt_s = MW'(1);
      end
      publish_s = !invalid_s && (match_nxt_s == MATCH_MAX)
                  && (!valid_r || (last_nxt_s != digit_r));
    end else begin
      publish_s = 1'b0;
    end
  end

  // Voter state and published result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r  <= '0;
      match_r <= '0;
      digit_r <= '0;
      valid_r <= 1'b0;
      upd_r   <= 1'b0;
    end else if (clear) begin
      last_r  <= '0;
      match_r <= '0;
      valid_r <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      last_r  <= last_nxt_s;
      match_r <= match_nxt_s;
      upd_r   <= publish_s;
      if (publish_s) begin
        digit_r <= last_nxt_s;
        valid_r <= 1'b1;
      end
    end
  end

  assign digit       = digit_r;
  assign digit_valid = valid_r;
  assign digit_upd   = upd_r;

endmodule

// File: rtl/recog_frame_ctrl.sv
// Frame-level sequencer stepping locate -> project -> recognise, one phase per frame,
// with per-phase frame timeouts and a stability voter on the recognition result.
module recog_frame_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int STABLE_CNT     = DEF_STABLE_CNT,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES,
  parameter int NUM_WIDTH      = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_vsync,
  input  logic                 restart,
  input  logic                 target_done,
  input  logic                 project_done,
  input  logic [NUM_WIDTH-1:0] digit_in,
  output logic                 locate_en,
  output logic                 project_en,
  output logic                 recog_en,
  output logic [1:0]           frame_cnt,
  output logic [NUM_WIDTH-1:0] digit,
  output logic                 digit_valid,
  output logic                 digit_upd,
  output logic                 timeout_err,
  output logic                 led
);

  localparam int            WW     = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [WW-1:0] TO_MAX = WW'(TIMEOUT_FRAMES);

  ctrl_state_t   state_r, state_nxt_s;
  logic [WW-1:0] wait_r, wait_nxt_s, wait_inc_s;
  logic          vs_d_r, fb_s;
  logic          tgt_seen_r, prj_seen_r, tgt_seen_s, prj_seen_s;
  logic          timeout_s, sample_s;
  logic          locate_nxt_s, project_nxt_s, recog_nxt_s;
  logic          locate_r, project_r, recog_r, timeout_r;
  logic [1:0]    frame_cnt_r;
  logic          voter_valid_s;

  assign fb_s       = frame_vsync & ~vs_d_r;
  // A done flag raised in the boundary cycle still belongs to the frame that is ending.
  assign tgt_seen_s = tgt_seen_r | target_done;
  assign prj_seen_s = prj_seen_r | project_done;
  assign wait_inc_s = wait_r + WW'(1);

  // Vsync edge detector, sticky done latches and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_r      <= 1'b1;
      tgt_seen_r  <= 1'b0;
      prj_seen_r  <= 1'b0;
      frame_cnt_r <= 2'd0;
    end else begin
      vs_d_r <= frame_vsync;
      if (fb_s) begin
        frame_cnt_r <= frame_cnt_r + 2'd1;
      end
      if (restart || fb_s) begin
        tgt_seen_r <= 1'b0;
        prj_seen_r <= 1'b0;
      end else begin
        tgt_seen_r <= tgt_seen_s;
        prj_seen_r <= prj_seen_s;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      wait_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
    end
  end

  // Next-state logic; restart overrides a coincident frame boundary.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_r;
    timeout_s   = 1'b0;
    sample_s    = 1'b0;
    if (restart) begin
      state_nxt_s = IDLE;
      wait_nxt_s  = '0;
    end else if (fb_s) begin
      case (state_r)
        IDLE: begin
          state_nxt_s = LOCATE;
          wait_nxt_s  = '0;
        end
        LOCATE: begin
          if (tgt_seen_s) begin
            state_nxt_s = PROJECT;
            wait_nxt_s  = '0;
          end else if (wait_inc_s == TO_MAX) begin
            timeout_s  = 1'b1;
            wait_nxt_s = '0;
          end else begin
            wait_nxt_s = wait_inc_s;
          end
        end
        PROJECT: begin
          if (prj_seen_s) begin
            state_nxt_s = RECOG;
            wait_nxt_s  = '0;
          end else if (wait_inc_s == TO_MAX) begin
            timeout_s   = 1'b1;
            state_nxt_s = LOCATE;
            wait_nxt_s  = '0;
          end else begin
            wait_nxt_s = wait_inc_s;
          end
        end
        RECOG: begin
          sample_s    = 1'b1;
          state_nxt_s = LOCATE;
          wait_nxt_s  = '0;
        end
        default: begin
          state_nxt_s = IDLE;
          wait_nxt_s  = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Enables are decoded from the next state so the registered copies track state_r.
  always_comb begin
    locate_nxt_s  = 1'b0;
    project_nxt_s = 1'b0;
    recog_nxt_s   = 1'b0;
    case (state_nxt_s)
      LOCATE:  locate_nxt_s  = 1'b1;
      PROJECT: project_nxt_s = 1'b1;
      RECOG:   recog_nxt_s   = 1'b1;
      default: locate_nxt_s  = 1'b0;
    endcase
  end

  // Registered enables and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locate_r  <= 1'b0;
      project_r <= 1'b0;
      recog_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      locate_r  <= locate_nxt_s;
      project_r <= project_nxt_s;
      recog_r   <= recog_nxt_s;
      timeout_r <= timeout_s;
    end
  end

  digit_voter #(
    .STABLE_CNT (STABLE_CNT),
    .NUM_WIDTH  (NUM_WIDTH)
  ) u_voter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (restart),
    .sample      (sample_s),
    .digit_in    (digit_in),
    .digit       (digit),
    .digit_valid (voter_valid_s),
    .digit_upd   (digit_upd)
  );

  assign locate_en   = locate_r;
  assign project_en  = project_r;
  assign recog_en    = recog_r;
  assign timeout_err = timeout_r;
  assign frame_cnt   = frame_cnt_r;
  assign digit_valid = voter_valid_s;
  assign led         = voter_valid_s;

endmodule

// File: tb/tb_recog_frame_ctrl.sv
// Directed bench for recog_frame_ctrl: a frame-level reference model pushes the
// expected post-boundary outputs to a scoreboard that is popped after each boundary.
module tb_recog_frame_ctrl;
  import img_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, frame_vsync, restart, target_done, project_done;
  logic [19:0] digit_in;
  logic        locate_en, project_en, recog_en, digit_valid, digit_upd, timeout_err, led;
  logic [1:0]  frame_cnt;
  logic [19:0] digit;

  typedef struct packed {
    logic       l, p, r;
    logic [1:0] fc;
    logic [19:0] d;
    logic       v, u, t;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  ctrl_state_t m_state;
  int          m_wait, m_match;
  logic [19:0] m_last, m_digit;
  logic        m_valid, m_upd, m_to;
  logic [1:0]  m_fc;

  recog_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .restart(restart),
    .target_done(target_done), .project_done(project_done), .digit_in(digit_in),
    .locate_en(locate_en), .project_en(project_en), .recog_en(recog_en),
    .frame_cnt(frame_cnt), .digit(digit), .digit_valid(digit_valid),
    .digit_upd(digit_upd), .timeout_err(timeout_err), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_wait = 0; m_match = 0; m_last = 20'h0;
    m_digit = 20'h0; m_valid = 1'b0; m_upd = 1'b0; m_to = 1'b0; m_fc = 2'd0;
  endtask

  task automatic model_sample(input logic [19:0] din);
    logic bad;
    logic [19:0] v;
    v = din;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) if (v[i*4 +: 4] == 4'hF) bad = 1'b1;
    if (bad) m_match = 0;
    else if (v == m_last) m_match = (m_match + 1 > DEF_STABLE_CNT) ? DEF_STABLE_CNT : m_match + 1;
    else begin m_last = v; m_match = 1; end
    if (!bad && m_match == DEF_STABLE_CNT && (!m_valid || m_last != m_digit)) begin
      m_digit = m_last; m_valid = 1'b1; m_upd = 1'b1;
    end
  endtask

  task automatic model_fb(input logic tgt, input logic prj, input logic [19:0] din, input logic rs);
    m_upd = 1'b0; m_to = 1'b0;
    m_fc = m_fc + 2'd1;
    if (rs) begin
      m_state = IDLE; m_wait = 0; m_match = 0; m_last = 20'h0; m_valid = 1'b0;
    end else begin
      case (m_state)
        IDLE: begin m_state = LOCATE; m_wait = 0; end
        LOCATE: begin
          if (tgt) begin m_state = PROJECT; m_wait = 0; end
          else begin
            m_wait++;
            if (m_wait == DEF_TIMEOUT_FRAMES) begin m_to = 1'b1; m_wait = 0; end
          end
        end
        PROJECT: begin
          if (prj) begin m_state = RECOG; m_wait = 0; end
          else begin
            m_wait++;
            if (m_wait == DEF_TIMEOUT_FRAMES) begin m_to = 1'b1; m_wait = 0; m_state = LOCATE; end
          end
        end
        default: begin model_sample(din); m_state = LOCATE; m_wait = 0; end
      endcase
    end
  endtask

  // One frame: three quiet cycles then the vsync rise; done flags mid-frame or on the boundary.
  task automatic run_frame(input logic tgt, input logic prj, input logic [19:0] din,
                           input logic at_fb, input logic rs);
    exp_t e;
    frame_vsync = 1'b0; digit_in = din;
    target_done = tgt & ~at_fb; project_done = prj & ~at_fb;
    tick();
    chk("upd_one_cycle", {31'd0, digit_upd}, 32'd0);
    chk("timeout_one_cycle", {31'd0, timeout_err}, 32'd0);
    target_done = 1'b0; project_done = 1'b0;
    tick();
    tick();
    frame_vsync = 1'b1; restart = rs;
    target_done = tgt & at_fb; project_done = prj & at_fb;
    model_fb(tgt, prj, din, rs);
    e.l = (m_state == LOCATE); e.p = (m_state == PROJECT); e.r = (m_state == RECOG);
    e.fc = m_fc; e.d = m_digit; e.v = m_valid; e.u = m_upd; e.t = m_to;
    sb.push_back(e);
    tick();
    restart = 1'b0; target_done = 1'b0; project_done = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("locate_en", {31'd0, locate_en}, {31'd0, e.l});
      chk("project_en", {31'd0, project_en}, {31'd0, e.p});
      chk("recog_en", {31'd0, recog_en}, {31'd0, e.r});
      chk("frame_cnt", {30'd0, frame_cnt}, {30'd0, e.fc});
      chk("digit", {12'd0, digit}, {12'd0, e.d});
      chk("digit_valid", {31'd0, digit_valid}, {31'd0, e.v});
      chk("led", {31'd0, led}, {31'd0, e.v});
      chk("digit_upd", {31'd0, digit_upd}, {31'd0, e.u});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.t});
    end
  endtask

  task automatic pass3(input logic [19:0] din);
    for (int k = 0; k < 3; k++) run_frame(1'b1, 1'b1, din, 1'b0, 1'b0);
  endtask

  initial begin
    logic [19:0] seq_a [5];
    logic [19:0] seq_b [6];
    seq_a = '{20'h12345, 20'h12346, 20'h12345, 20'h12345, 20'h12345};
    seq_b = '{20'h54321, 20'h54321, 20'h1F345, 20'h54321, 20'h54321, 20'h54321};

    rst_n = 1'b0; frame_vsync = 1'b0; restart = 1'b0;
    target_done = 1'b0; project_done = 1'b0; digit_in = 20'h0;
    model_reset();
    #12;
    chk("rst_enables", {29'd0, locate_en, project_en, recog_en}, 32'd0);
    chk("rst_digit", {12'd0, digit}, 32'd0);
    chk("rst_flags", {28'd0, digit_valid, digit_upd, timeout_err, led}, 32'd0);
    chk("rst_frame_cnt", {30'd0, frame_cnt}, 32'd0);
    frame_vsync = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("no_fb_after_reset", {29'd0, locate_en, project_en, recog_en}, 32'd0);
    chk("no_fb_frame_cnt", {30'd0, frame_cnt}, 32'd0);

    // First boundary enters LOCATE, then three full passes publish 12345.
    run_frame(1'b1, 1'b1, 20'h12345, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pass3(20'h12345);

    // A restart drops digit_valid; the changing run only publishes on its fifth sample.
    restart = 1'b1;
    model_fb(1'b0, 1'b0, 20'h0, 1'b1);
    m_fc = m_fc - 2'd1;
    tick();
    restart = 1'b0;
    chk("restart_valid", {31'd0, digit_valid}, 32'd0);
    chk("restart_idle", {29'd0, locate_en, project_en, recog_en}, 32'd0);
    chk("restart_digit_kept", {12'd0, digit}, 32'h12345);
    run_frame(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) pass3(seq_a[k]);

    // Locate timeout stays in LOCATE; project timeout falls back to LOCATE.
    for (int k = 0; k < 4; k++) run_frame(1'b0, 1'b1, 20'h0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) run_frame(1'b1, 1'b0, 20'h0, 1'b0, 1'b0);

    // Unrecognised nibble in a stable run resets the match without touching digit.
    for (int k = 0; k < 6; k++) pass3(seq_b[k]);

    // Done on the boundary cycle counts; restart beats a coincident boundary.
    run_frame(1'b1, 1'b0, 20'h0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b1, 20'h0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame clears everything between clock edges.
    frame_vsync = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_enables", {29'd0, locate_en, project_en, recog_en}, 32'd0);
    chk("async_rst_digit", {12'd0, digit}, 32'd0);
    chk("async_rst_flags", {30'd0, digit_valid, frame_cnt == 2'd0 ? 1'b0 : 1'b1}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
